// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: byte-wide write engine for an HD44780-style character LCD.
// After reset it waits out the panel power-up time, then sends the init bytes
// 0x38, 0x0C, 0x01, 0x06 and raises init_done. From then on it takes one byte
// at a time from a valid/ready upstream and strobes it onto the LCD bus with
// setup, enable-high, hold and post-write wait phases.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   in_valid   upstream offers a byte
//   in_ready   block accepts a byte this cycle (IDLE and init_done)
//   in_rs      0 = command, 1 = character data
//   in_data    byte to write
//   busy       FSM is not in IDLE
//   init_done  power-up init complete, held until reset
//   lcd_rs     LCD RS
//   lcd_rw     LCD RW, tied low (write-only)
//   lcd_en     LCD E, registered
//   lcd_data   LCD DB7..DB0
//
// state | meaning
// PWRUP | waiting T_PWRUP cycles for the panel supply to settle
// INIT  | one cycle: load the next init byte onto the bus
// IDLE  | waiting for an upstream byte
// SETUP | RS/DATA stable, E low
// EN_HI | E high
// HOLD  | E low, RS/DATA still held
// WAIT  | post-write execution time (long for clear/home)

module lcd_byte_writer #(
   parameter int T_PWRUP = 750000,
   parameter int T_SETUP = 4,
   parameter int T_EN    = 12,
   parameter int T_HOLD  = 4,
   parameter int T_CMD   = 2000,
   parameter int T_LONG  = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_rs,
   input  logic [7:0] in_data,
   output logic       busy,
   output logic       init_done,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   localparam int T_MAX = (T_PWRUP > T_LONG) ? T_PWRUP : T_LONG;
   localparam int CW    = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {
      S_PWRUP,
      S_INIT,
      S_IDLE,
      S_SETUP,
      S_EN_HI,
      S_HOLD,
      S_WAIT
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_load;
   logic [2:0]    init_cnt;
   logic [7:0]    init_byte;
   logic          tc;
   logic          accept;
   logic          long_wait;

   // Counter is loaded with the full duration on entry, so a state lasts
   // exactly its T cycles when it leaves at count 1.
   assign tc        = (cnt <= CW'(1));
   assign accept    = in_valid & in_ready;
   assign long_wait = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02 ||
                                  lcd_data == 8'h03);
   assign lcd_rw    = 1'b0;

   always_comb begin
      init_byte = 8'h38;
      case (init_cnt[1:0])
         2'd0:    init_byte = 8'h38;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h01;
         default: init_byte = 8'h06;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_PWRUP;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_PWRUP: if (tc) state_nxt = S_INIT;
         S_INIT:  state_nxt = S_SETUP;
         S_IDLE:  if (accept) state_nxt = S_SETUP;
         S_SETUP: if (tc) state_nxt = S_EN_HI;
         S_EN_HI: if (tc) state_nxt = S_HOLD;
         S_HOLD:  if (tc) state_nxt = S_WAIT;
         S_WAIT:  if (tc) state_nxt = (init_done || init_cnt == 3'd4) ? S_IDLE : S_INIT;
         default: state_nxt = S_PWRUP;
      endcase
   end

   // output logic
   always_comb begin
      in_ready = (state == S_IDLE) && init_done;
      busy     = (state != S_IDLE);
   end

   always_comb begin
      cnt_load = CW'(1);
      case (state_nxt)
         S_PWRUP: cnt_load = CW'(T_PWRUP);
         S_SETUP: cnt_load = CW'(T_SETUP);
         S_EN_HI: cnt_load = CW'(T_EN);
         S_HOLD:  cnt_load = CW'(T_HOLD);
         S_WAIT:  cnt_load = long_wait ? CW'(T_LONG) : CW'(T_CMD);
         default: cnt_load = CW'(1);
      endcase
   end

   // timer, bus registers and init progress
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= CW'(T_PWRUP);
         init_cnt  <= 3'd0;
         init_done <= 1'b0;
         lcd_en    <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= 8'h00;
      end else begin
         if (state_nxt != state) cnt <= cnt_load;
         else if (cnt != '0)     cnt <= cnt - CW'(1);

         lcd_en <= (state_nxt == S_EN_HI);

         if (state == S_INIT) begin
            lcd_rs   <= 1'b0;
            lcd_data <= init_byte;
            init_cnt <= init_cnt + 3'd1;
         end else if (accept) begin
            lcd_rs   <= in_rs;
            lcd_data <= in_data;
         end

         if (state == S_WAIT && tc && !init_done && init_cnt == 3'd4)
            init_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Testbench for lcd_byte_writer with shortened timing parameters.
// Directed vectors; all outputs sampled on the falling clock edge.

module tb_lcd_byte_writer;

   localparam int T_PWRUP = 20;
   localparam int T_SETUP = 2;
   localparam int T_EN    = 3;
   localparam int T_HOLD  = 2;
   localparam int T_CMD   = 10;
   localparam int T_LONG  = 40;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic       in_rs;
   logic [7:0] in_data;
   logic       busy;
   logic       init_done;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic [7:0] lcd_data;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   int         rise_cyc[$];
   logic [7:0] rise_dat[$];
   logic       rise_rs[$];
   int         fall_cyc[$];
   int         rw_bad = 0;
   int         viol   = 0;
   logic       prev_en;
   logic       prev_rs;
   logic [7:0] prev_d;

   lcd_byte_writer #(
      .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
      .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_LONG(T_LONG)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rs     (in_rs),
      .in_data   (in_data),
      .busy      (busy),
      .init_done (init_done),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_en    (lcd_en),
      .lcd_data  (lcd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (lcd_rw !== 1'b0) rw_bad++;
      if (lcd_en === 1'b1 && prev_en !== 1'b1) begin
         rise_cyc.push_back(cyc);
         rise_dat.push_back(lcd_data);
         rise_rs.push_back(lcd_rs);
      end
      if (lcd_en !== 1'b1 && prev_en === 1'b1) fall_cyc.push_back(cyc);
      if (lcd_en === 1'b1 && prev_en === 1'b1 &&
          (lcd_data !== prev_d || lcd_rs !== prev_rs)) viol++;
      prev_en = lcd_en;
      prev_rs = lcd_rs;
      prev_d  = lcd_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int t = 0;
      while (in_ready !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk(tag, (t < 1000) ? 1 : 0, 1);
   endtask

   // r is the first PWRUP cycle; base is the pulse index where init starts.
   task automatic check_init(input int r, input int base);
      logic [7:0] exp_b[4];
      int t;
      int w;
      int r_exp;
      int r_last;
      int done_cyc;
      exp_b[0] = 8'h38;
      exp_b[1] = 8'h0C;
      exp_b[2] = 8'h01;
      exp_b[3] = 8'h06;
      t = 0;
      while (init_done !== 1'b1 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("init_timeout", (t < 5000) ? 1 : 0, 1);
      done_cyc = cyc;
      chk("init_ready", in_ready, 1);
      chk("init_npulse", rise_cyc.size() - base, 4);
      r_exp  = r + T_PWRUP + 1 + T_SETUP;
      r_last = r_exp;
      for (int k = 0; k < 4; k++) begin
         w = (exp_b[k] == 8'h01) ? T_LONG : T_CMD;
         if (base + k < rise_cyc.size() && base + k < fall_cyc.size()) begin
            chk($sformatf("init%0d_rise", k), rise_cyc[base+k], r_exp);
            chk($sformatf("init%0d_data", k), rise_dat[base+k], exp_b[k]);
            chk($sformatf("init%0d_rs", k), rise_rs[base+k], 0);
            chk($sformatf("init%0d_width", k), fall_cyc[base+k] - rise_cyc[base+k], T_EN);
            if (k < 3 && base + k + 1 < rise_cyc.size())
               chk($sformatf("init%0d_gap", k), rise_cyc[base+k+1] - fall_cyc[base+k],
                   T_HOLD + w + 1 + T_SETUP);
         end
         r_last = r_exp;
         r_exp  = r_exp + T_EN + T_HOLD + w + 1 + T_SETUP;
      end
      chk("init_done_cyc", done_cyc, r_last + T_EN + T_HOLD + T_CMD);
   endtask

   task automatic send(input logic rs, input logic [7:0] d, input int exp_lat);
      int acc0;
      int base;
      wait_ready("send_ready_timeout");
      acc0     = cyc;
      base     = rise_cyc.size();
      in_valid = 1'b1;
      in_rs    = rs;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~d;
      in_rs    = ~rs;
      chk($sformatf("send%02h_data", d), lcd_data, d);
      chk($sformatf("send%02h_rs", d), lcd_rs, rs);
      chk($sformatf("send%02h_rdy_lo", d), in_ready, 0);
      chk($sformatf("send%02h_busy", d), busy, 1);
      wait_ready("send_done_timeout");
      chk($sformatf("send%02h_lat", d), cyc - acc0, exp_lat);
      chk($sformatf("send%02h_npulse", d), rise_cyc.size() - base, 1);
      if (rise_cyc.size() > base && fall_cyc.size() > base) begin
         chk($sformatf("send%02h_en_rise", d), rise_cyc[base] - acc0, 3);
         chk($sformatf("send%02h_en_fall", d), fall_cyc[base] - acc0, 6);
         chk($sformatf("send%02h_en_data", d), rise_dat[base], d);
      end
      chk($sformatf("send%02h_hold_data", d), lcd_data, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       v_rs[7];
      logic [7:0] v_d[7];
      int         v_lat[7];
      int         r;
      int         acc0;
      int         base;
      int         t;
      logic       held_ok;
      logic [7:0] d2;

      v_rs[0] = 1'b1; v_d[0] = 8'h41; v_lat[0] = 18;
      v_rs[1] = 1'b0; v_d[1] = 8'h01; v_lat[1] = 48;
      v_rs[2] = 1'b0; v_d[2] = 8'h80; v_lat[2] = 18;
      v_rs[3] = 1'b0; v_d[3] = 8'h02; v_lat[3] = 48;
      v_rs[4] = 1'b0; v_d[4] = 8'h03; v_lat[4] = 48;
      v_rs[5] = 1'b1; v_d[5] = 8'h01; v_lat[5] = 18;
      v_rs[6] = 1'b0; v_d[6] = 8'h04; v_lat[6] = 18;

      // Reset with in_valid already high: it must be ignored through init.
      reset    = 1'b1;
      in_valid = 1'b1;
      in_rs    = 1'b1;
      in_data  = 8'hAA;
      @(negedge clk);
      reset = 1'b0;
      r     = cyc;
      chk("rst_en", lcd_en, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_data", lcd_data, 8'h00);
      chk("rst_ready", in_ready, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_busy", busy, 1);
      for (int i = 0; i < 60; i++) @(negedge clk);
      in_valid = 1'b0;
      check_init(r, 0);

      for (int i = 0; i < 7; i++) send(v_rs[i], v_d[i], v_lat[i]);

      // Held in_valid with changing data: only the first byte is taken until
      // in_ready returns, then whatever is on the bus that cycle is taken.
      wait_ready("hold_ready_timeout");
      acc0     = cyc;
      base     = rise_cyc.size();
      in_valid = 1'b1;
      in_rs    = 1'b1;
      in_data  = 8'h50;
      held_ok  = 1'b1;
      t        = 0;
      while (t < 1000) begin
         @(negedge clk);
         t++;
         if (lcd_data !== 8'h50) held_ok = 1'b0;
         if (in_ready === 1'b1) break;
         in_data = 8'h60 + 8'(t);
      end
      d2 = in_data;
      chk("hold_first_stays", held_ok, 1);
      chk("hold_lat", cyc - acc0, 18);
      chk("hold_npulse", rise_cyc.size() - base, 1);
      if (rise_cyc.size() > base) chk("hold_pulse_data", rise_dat[base], 8'h50);
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold_next_data", lcd_data, d2);
      chk("hold_next_rdy_lo", in_ready, 0);
      wait_ready("hold_done_timeout");

      // Reset during EN_HI aborts the write and restarts power-up and init.
      in_valid = 1'b1;
      in_rs    = 1'b1;
      in_data  = 8'h41;
      @(negedge clk);
      in_valid = 1'b0;
      t = 0;
      while (lcd_en !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("abort_saw_en", lcd_en, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      r     = cyc;
      chk("abort_en", lcd_en, 0);
      chk("abort_init_done", init_done, 0);
      chk("abort_busy", busy, 1);
      chk("abort_ready", in_ready, 0);
      chk("abort_data", lcd_data, 8'h00);
      chk("abort_rs", lcd_rs, 0);
      base = rise_cyc.size();
      check_init(r, base);

      send(1'b1, 8'h5A, 18);

      chk("rw_low_always", rw_bad, 0);
      chk("bus_stable_during_en", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_byte_writer.md
LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

Parameters
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- T_PWRUP, 750000, power-up wait cycles (15 ms @ 50 MHz).
- T_SETUP, 4, cycles RS/DATA stable before EN rises.
- T_EN, 12, cycles EN held high.
- T_HOLD, 4, cycles RS/DATA held after EN falls.
- T_CMD, 2000, post-write wait cycles, normal byte (40 us).
- T_LONG, 82000, post-write wait cycles, clear/home (1.64 ms).

Interface
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream (Avalon slave side) offers a byte.
- in_ready  out  1  block can accept a byte this cycle.
- in_rs  in  1  0 = command, 1 = character data.
- in_data  in  8  byte to write.
- busy  out  1  high whenever the FSM is not in IDLE.
- init_done  out  1  power-up init sequence complete; stays high until reset.
- lcd_rs  out  1  HD44780 RS.
- lcd_rw  out  1  HD44780 RW; constant 0 (write-only).
- lcd_en  out  1  HD44780 E.
- lcd_data  out  8  HD44780 DB7..DB0.

Function
REQ-003 FSM states SHALL be PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT.
REQ-004 PWRUP SHALL count T_PWRUP cycles, then enter INIT.
REQ-005 INIT SHALL issue, in order, 0x38, 0x0C, 0x01, 0x06, all with rs=0, each through SETUP/EN_HI/HOLD/WAIT.
REQ-006 After the 4th init byte's WAIT, init_done SHALL rise and the FSM SHALL enter IDLE.
REQ-007 in_ready SHALL be 1 only in IDLE with init_done=1.
REQ-008 Transfer accepted when in_valid & in_ready are both high at a clock edge.
- in_rs/in_data latched at that edge.
- in_ready low from the next cycle.
REQ-009 in_valid while in_ready=0 SHALL be ignored: no latch, no side effect.
REQ-010 Cycle after acceptance: lcd_rs/lcd_data SHALL show the latched values and the FSM SHALL enter SETUP.
REQ-011 Write timing:
- SETUP lasts T_SETUP cycles, lcd_en=0.
- EN_HI lasts T_EN cycles, lcd_en=1.
- HOLD lasts T_HOLD cycles, lcd_en=0.
REQ-012 WAIT SHALL last T_LONG when rs=0 and data in {0x01,0x02,0x03}, else T_CMD, then return to IDLE (or the next INIT byte).
REQ-013 lcd_rs/lcd_data SHALL hold their last value in IDLE; they change only at a new acceptance.
REQ-014 Accept-to-in_ready-high latency SHALL be exactly 1+T_SETUP+T_EN+T_HOLD+wait cycles.
REQ-015 One down-counter SHALL serve all timed states.
- Width: enough for max(T_PWRUP, T_LONG).
- Reloaded on every state entry; no wrap-around.
REQ-016 busy SHALL equal (state != IDLE).
REQ-017 lcd_en SHALL be glitch-free, driven from a register.

Reset
REQ-018 While reset=1 at a clock edge, next-cycle outputs SHALL be:
- lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00.
- in_ready=0, init_done=0, busy=1.
- state=PWRUP, counter reloaded to T_PWRUP.
REQ-019 Reset asserted mid-transfer (any state, including EN_HI) SHALL abort the transfer.
- lcd_en=0 on the next cycle.
- Full power-up and init sequence restarts.

Verification (T_PWRUP=20, T_SETUP=2, T_EN=3, T_HOLD=2, T_CMD=10, T_LONG=40)
REQ-020 Reset 1 cycle, then idle -> exactly four EN pulses (3 cycles each) carrying 0x38, 0x0C, 0x01, 0x06 with rs=0.
- Gap after 0x01 is 40 wait cycles; others 10.
- init_done rises after the last wait.
REQ-021 After init, send in_rs=1, in_data=0x41 -> lcd_data=0x41, lcd_rs=1 next cycle.
- EN high at cycles 3..5 after acceptance.
- in_ready returns 18 cycles after acceptance.
REQ-022 Send command 0x01 -> in_ready returns 48 cycles after acceptance; command 0x80 -> 18 cycles.
REQ-023 Hold in_valid=1 with changing data during a transfer -> only the first byte appears on lcd_data.
- Next byte accepted on the first in_ready=1 cycle.
REQ-024 Assert reset during EN_HI -> lcd_en=0 next cycle, init_done=0, PWRUP wait of 20 cycles, init sequence repeats.
REQ-025 Entire run -> lcd_rw=0 every cycle; lcd_data/lcd_rs never change while lcd_en=1.
